alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 116 +++++++++++
 tb/tb_alu_exec_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Two-stage pipelined integer ALU execution unit with valid/ready handshakes.
// S1 registers the issued operands; S2 registers the computed result.
package parameter_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;
endpackage

module alu_exec_unit #(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 5,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    input  logic [ROB_W-1:0]  rob_tag,
    input  logic [PREG_W-1:0] pdest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [ROB_W-1:0]  out_rob_tag,
    output logic [PREG_W-1:0] out_pdest
);
    import parameter_pkg::*;

    localparam int SH_W = $clog2(XLEN);

    logic              s1_valid;
    logic [3:0]        s1_op;
    logic [XLEN-1:0]   s1_a;
    logic [XLEN-1:0]   s1_b;
    logic [ROB_W-1:0]  s1_tag;
    logic [PREG_W-1:0] s1_pdest;
    logic              s2_valid;

    logic              s2_adv;
    logic              s1_adv;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   alu_res;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv && !flush;
    assign out_valid = s2_valid;
    assign shamt     = s1_b[SH_W-1:0];

    // Unused codes 10-15 fall through to ADD.
    always_comb begin
        alu_res = s1_a + s1_b;
        case (s1_op)
            OP_SUB:  alu_res = s1_a - s1_b;
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_AND:  alu_res = s1_a & s1_b;
            OP_SLL:  alu_res = s1_a << shamt;
            OP_SRL:  alu_res = s1_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(s1_a) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                $signed(s1_a) < $signed(s1_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, s1_a < s1_b};
            default: alu_res = s1_a + s1_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_op       <= '0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_tag      <= '0;
            s1_pdest    <= '0;
            s2_valid    <= 1'b0;
            result      <= '0;
            out_rob_tag <= '0;
            out_pdest   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result      <= alu_res;
                    out_rob_tag <= s1_tag;
                    out_pdest   <= s1_pdest;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op    <= alu_control;
                    s1_a     <= src1;
                    s1_b     <= src2;
                    s1_tag   <= rob_tag;
                    s1_pdest <= pdest;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random bench for alu_exec_unit using an expected-result queue.
// Handshakes are evaluated 1ns after the falling edge, away from the active edge.
module tb_alu_exec_unit;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [5:0]  pd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  rob_tag;
    logic [5:0]  pdest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_rob_tag;
    logic [5:0]  out_pdest;

    exp_t        sb[$];
    logic [31:0] cur_exp;
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          nout = 0;
    int          first_out = -1;
    int          last_out = -1;
    int          nacc = 0;

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src1(src1), .src2(src2),
        .rob_tag(rob_tag), .pdest(pdest),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_rob_tag(out_rob_tag),
        .out_pdest(out_pdest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ext;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            4'd1: return a + (~b) + 32'd1;
            4'd2: return (a | b) & ~(a & b);
            4'd3: return a | b;
            4'd4: return a & b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            4'd8: return (a[31] != b[31]) ? {31'd0, a[31]}
                                           : {31'd0, a < b};
            4'd9: return {31'd0, a < b};
            default: return a + b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_k(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] t,
                           input logic [5:0] p, input logic [31:0] k);
        in_valid    = 1'b1;
        alu_control = op;
        src1        = a;
        src2        = b;
        rob_tag     = t;
        pdest       = p;
        cur_exp     = k;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t,
                         input logic [5:0] p);
        drive_k(op, a, b, t, p, alu_ref(op, a, b));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One cycle: score handshakes, then step to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("out_rob_tag", {27'd0, out_rob_tag}, {27'd0, e.tag});
                chk("out_pdest", {26'd0, out_pdest}, {26'd0, e.pd});
            end
            nout++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (in_valid && in_ready) begin
            e.res = cur_exp;
            e.tag = rob_tag;
            e.pd  = pdest;
            sb.push_back(e);
            nacc++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int k;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;

        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        alu_control = 4'd0;
        src1 = '0;
        src2 = '0;
        rob_tag = '0;
        pdest = '0;
        out_ready = 1'b1;
        cur_exp = '0;

        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", {27'd0, out_rob_tag}, 32'd0);
        chk("rst_pdest", {26'd0, out_pdest}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Basic ADD with 2-cycle latency
        drive_k(4'd0, 32'd5, 32'd7, 5'd3, 6'd9, 32'd12);
        tick();
        idle();
        #1;
        chk("lat_cycle1_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        #1;
        chk("lat_cycle2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_result", result, 32'd12);
        tick();

        // Arithmetic corners, back to back
        drive_k(4'd1, 32'd0, 32'd1, 5'd1, 6'd1, 32'hFFFF_FFFF);
        tick();
        drive_k(4'd7, 32'h8000_0000, 32'd4, 5'd2, 6'd2, 32'hF800_0000);
        tick();
        drive_k(4'd6, 32'h8000_0000, 32'd4, 5'd3, 6'd3, 32'h0800_0000);
        tick();
        drive_k(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd4, 6'd4, 32'd1);
        tick();
        drive_k(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd5, 6'd5, 32'd0);
        tick();
        drive_k(4'd12, 32'd40, 32'd2, 5'd6, 6'd6, 32'd42);
        tick();
        drive_k(4'd5, 32'h0000_0003, 32'd36, 5'd7, 6'd7, 32'h0000_0030);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("corners_drained", sb.size(), 32'd0);

        // Backpressure: 4 ADDs, out_ready low for a while
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (k < 4) drive(4'd0, k, 32'd1, 5'(10 + k), 6'(20 + k));
            else idle();
            #1;
            if (i >= 2) begin
                chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_result_stable", result, 32'd1);
                chk("bp_tag_stable", {27'd0, out_rob_tag}, 32'd10);
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (k < 4) drive(4'd0, k, 32'd1, 5'(10 + k), 6'(20 + k));
            else idle();
            #1;
            chk("bp_release_consecutive", {31'd0, out_valid}, 32'd1);
            if (in_valid && in_ready) k++;
            tick();
        end
        idle();
        tick();
        chk("bp_all_accepted", k, 32'd4);
        chk("bp_drained", sb.size(), 32'd0);

        // Flush with two ops in flight and an op offered in the flush cycle
        drive(4'd2, 32'hA5A5_0000, 32'h0F0F_0F0F, 5'd1, 6'd1);
        tick();
        drive(4'd3, 32'h1234_0000, 32'h0000_5678, 5'd2, 6'd2);
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        drive(4'd4, 32'hFFFF_0000, 32'h00FF_FF00, 5'd3, 6'd3);
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        sb.delete();
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end

        // Asynchronous reset while stalled
        out_ready = 1'b0;
        drive(4'd0, 32'd100, 32'd1, 5'd4, 6'd4);
        tick();
        drive(4'd0, 32'd200, 32'd1, 5'd5, 6'd5);
        tick();
        idle();
        #2;
        chk("stall_before_rst", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(4'd1, 32'd50, 32'd8, 5'd9, 6'd9);
        tick();
        idle();
        #1;
        chk("post_rst_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        #1;
        chk("post_rst_lat2", {31'd0, out_valid}, 32'd1);
        tick();
        chk("post_rst_drained", sb.size(), 32'd0);

        // Throughput: 16 random ops back to back
        nout = 0;
        nacc = 0;
        first_out = -1;
        last_out = -1;
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom();
            b = (i % 4 == 0) ? 32'($urandom_range(0, 31)) : $urandom();
            drive(op, a, b, 5'(i), 6'(i + 32));
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();
        chk("tp_accepts", nacc, 32'd16);
        chk("tp_outputs", nout, 32'd16);
        chk("tp_consecutive", last_out - first_out, 32'd15);
        chk("tp_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
